// File: rtl/read_reg_hazard_pkg.sv
// Shared definitions for the read-register hazard unit: ISA opcode/funct
// encodings, forwarding-select codes and the scoreboard entry layout.
package read_reg_hazard_pkg;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes (instruction[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;

  // Operand source select driven onto fwdA/fwdB
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  // Scoreboard entry: {valid, dest[4:0], isLoad}
  localparam int unsigned SB_ENTRY_W = 7;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } sb_entry_t;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic src_match(input logic use_s, input sb_entry_t e,
                                     input logic [4:0] src);
    return use_s && e.valid && (e.dest != 5'd0) && (e.dest == src);
  endfunction

endpackage

// File: rtl/read_reg_hazard_decode.sv
// read_reg_decode: combinational source-usage decode of the ID instruction.
// Ports:
//   opcode  in  6  instruction[31:26]
//   funct   in  6  instruction[5:0]
//   useRs   out 1  instruction reads rs
//   useRt   out 1  instruction reads rt
//   isLoad  out 1  instruction is LB/LW
module read_reg_decode
  import read_reg_hazard_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       useRs,
  output logic       useRt,
  output logic       isLoad
);

  always_comb begin
    useRs  = 1'b0;
    useRt  = 1'b0;
    isLoad = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_JR:                  useRs = 1'b1;
          FN_SLL, FN_SRL, FN_SRA: useRt = 1'b1;
          default: begin
            useRs = 1'b1;
            useRt = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_REGIMM, OP_BLEZ, OP_BGTZ: useRs = 1'b1;
      OP_BEQ, OP_BNE, OP_SB, OP_SW: begin
        useRs = 1'b1;
        useRt = 1'b1;
      end
      OP_LB, OP_LW: begin
        useRs  = 1'b1;
        isLoad = 1'b1;
      end
      // LUI, J, JAL and unrecognised opcodes read no GPR
      default: ;
    endcase
  end

endmodule

// File: rtl/read_reg_hazard.sv
// read_reg_hazard: RAW/load-use hazard detection and forwarding selects for
// the ID-stage instruction against EX/MEM/WB destinations held in a 3-entry
// shift scoreboard.
// Configuration macro: HAZARD_FORWARDING_EN
//   defined   -> forward from nearest match (E > M > W), stall only on load-use
//   undefined -> fwdA=fwdB=0, stall on any match in E, M or W
// Ports:
//   clk, reset     clock (rising edge), synchronous active-high reset
//   idInstruction  instruction in ID          idValid   ID holds a real instruction
//   idWriteReg     destination of ID instr    flush     kill ID instruction
//   hold           freeze scoreboard/counter  idReady   ~stall
//   stall          hazard stall request       useRs/useRt  ID reads rs / rt
//   fwdA, fwdB     operand source select      stallCount   saturating stall cycles
module read_reg_hazard
  import read_reg_hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      idInstruction,
  input  logic             idValid,
  input  logic [4:0]       idWriteReg,
  input  logic             flush,
  input  logic             hold,
  output logic             idReady,
  output logic             stall,
  output logic             useRs,
  output logic             useRt,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic [CNT_W-1:0] stallCount
);

  logic       id_is_load;
  logic [4:0] rs, rt;
  sb_entry_t  sb_e, sb_m, sb_w;
  logic       m_e_s, m_m_s, m_w_s, m_e_t, m_m_t, m_w_t;
  logic       stall_req;
  fwd_sel_t   fwd_a, fwd_b;
  logic       sig_unused;

  assign rs = idInstruction[25:21];
  assign rt = idInstruction[20:16];

  read_reg_decode u_decode (
    .opcode (idInstruction[31:26]),
    .funct  (idInstruction[5:0]),
    .useRs  (useRs),
    .useRt  (useRt),
    .isLoad (id_is_load)
  );

  assign m_e_s = src_match(useRs, sb_e, rs);
  assign m_m_s = src_match(useRs, sb_m, rs);
  assign m_w_s = src_match(useRs, sb_w, rs);
  assign m_e_t = src_match(useRt, sb_e, rt);
  assign m_m_t = src_match(useRt, sb_m, rt);
  assign m_w_t = src_match(useRt, sb_w, rt);

  always_comb begin
    stall_req = 1'b0;
    fwd_a     = FWD_REG;
    fwd_b     = FWD_REG;
`ifdef HAZARD_FORWARDING_EN
    if (m_e_s)      fwd_a = FWD_EX;
    else if (m_m_s) fwd_a = FWD_MEM;
    else if (m_w_s) fwd_a = FWD_WB;
    if (m_e_t)      fwd_b = FWD_EX;
    else if (m_m_t) fwd_b = FWD_MEM;
    else if (m_w_t) fwd_b = FWD_WB;
    // Only a load in EX has no result yet; one bubble moves it to MEM.
    stall_req = (m_e_s | m_e_t) & sb_e.is_load;
`else
    stall_req = m_e_s | m_m_s | m_w_s | m_e_t | m_m_t | m_w_t;
`endif
  end

  // Flush dominates: a killed instruction never stalls.
  assign stall   = idValid & ~flush & stall_req;
  assign idReady = ~stall;
  assign fwdA    = fwd_a;
  assign fwdB    = fwd_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_e       <= '0;
      sb_m       <= '0;
      sb_w       <= '0;
      stallCount <= '0;
    end else begin
      if (!hold) begin
        sb_w <= sb_m;
        sb_m <= sb_e;
        if (idValid && !stall && !flush)
          sb_e <= '{valid: 1'b1, dest: idWriteReg, is_load: id_is_load};
        else
          sb_e <= '0;
      end
      if (stall && !hold && (stallCount != '1))
        stallCount <= stallCount + CNT_W'(1);
    end
  end

  // Immediate/shamt bits and the WB load flag do not affect hazards.
  assign sig_unused = ^{idInstruction[15:6], sb_w.is_load};

endmodule

// File: tb/tb_read_reg_hazard.sv
module tb_read_reg_hazard;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] idInstruction;
  logic        idValid;
  logic [4:0]  idWriteReg;
  logic        flush;
  logic        hold;
  logic        idReady, stall, useRs, useRt;
  logic [1:0]  fwdA, fwdB;
  logic [31:0] stallCount;
  logic        s_idReady, s_stall, s_useRs, s_useRt;
  logic [1:0]  s_fwdA, s_fwdB;
  logic [1:0]  s_stallCount;

  always #5 clk = ~clk;

  read_reg_hazard #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .idInstruction(idInstruction), .idValid(idValid),
    .idWriteReg(idWriteReg), .flush(flush), .hold(hold), .idReady(idReady),
    .stall(stall), .useRs(useRs), .useRt(useRt), .fwdA(fwdA), .fwdB(fwdB),
    .stallCount(stallCount)
  );

  // Narrow counter instance to reach saturation within a short run.
  read_reg_hazard #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .idInstruction(idInstruction), .idValid(idValid),
    .idWriteReg(idWriteReg), .flush(flush), .hold(hold), .idReady(s_idReady),
    .stall(s_stall), .useRs(s_useRs), .useRt(s_useRt), .fwdA(s_fwdA), .fwdB(s_fwdB),
    .stallCount(s_stallCount)
  );

  typedef struct {
    logic        stall;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic urs;
    logic urt;
  } use_t;

  exp_t        exp_q[$];
  use_t        use_q[$];
  int unsigned checks = 0;
  int unsigned passes = 0;
  logic [31:0] exp_cnt;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Drive one ID cycle, queue what the hazard unit must show, compare at negedge.
  task automatic cyc(input string tag, input logic [31:0] ins, input logic v,
                     input logic [4:0] wr, input logic fl, input logic hd,
                     input logic es, input logic [1:0] efa, input logic [1:0] efb);
    exp_t e;
    logic [1:0] esm;
    idInstruction = ins; idValid = v; idWriteReg = wr; flush = fl; hold = hd;
    e.stall = es; e.fa = efa; e.fb = efb; e.cnt = exp_cnt;
    exp_q.push_back(e);
    if (es && !hd) exp_cnt = exp_cnt + 32'd1;
    @(negedge clk);
    e = exp_q.pop_front();
    esm = (e.cnt > 32'd3) ? 2'd3 : e.cnt[1:0];
    checks++;
    if (stall !== e.stall) $display("FAIL %s stall: got %b expected %b", tag, stall, e.stall);
    else passes++;
    checks++;
    if (idReady !== ~e.stall) $display("FAIL %s idReady: got %b expected %b", tag, idReady, ~e.stall);
    else passes++;
    checks++;
    if (fwdA !== e.fa) $display("FAIL %s fwdA: got %0d expected %0d", tag, fwdA, e.fa);
    else passes++;
    checks++;
    if (fwdB !== e.fb) $display("FAIL %s fwdB: got %0d expected %0d", tag, fwdB, e.fb);
    else passes++;
    checks++;
    if (stallCount !== e.cnt) $display("FAIL %s stallCount: got %0d expected %0d", tag, stallCount, e.cnt);
    else passes++;
    checks++;
    if (s_stallCount !== esm) $display("FAIL %s satCount: got %0d expected %0d", tag, s_stallCount, esm);
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag);
    cyc(tag, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic do_reset;
    reset = 1'b1; idInstruction = '0; idValid = 1'b0; idWriteReg = '0;
    flush = 1'b0; hold = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_reset;
    do_reset();
    idle("rst_idle");
    cyc("rst_reader", rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic test_decode;
    logic [31:0] ins [12];
    logic [1:0]  ex  [12];
    use_t u;
    ins[0]  = rtype(5'd1, 5'd2, 5'd3, 6'h20);  ex[0]  = 2'b11; // ADD
    ins[1]  = rtype(5'd1, 5'd0, 5'd0, 6'h08);  ex[1]  = 2'b10; // JR
    ins[2]  = rtype(5'd0, 5'd2, 5'd3, 6'h00);  ex[2]  = 2'b01; // SLL
    ins[3]  = itype(6'h08, 5'd1, 5'd2, 16'h1); ex[3]  = 2'b10; // ADDI
    ins[4]  = itype(6'h0D, 5'd1, 5'd2, 16'h1); ex[4]  = 2'b10; // ORI
    ins[5]  = itype(6'h0F, 5'd1, 5'd2, 16'h1); ex[5]  = 2'b00; // LUI
    ins[6]  = itype(6'h01, 5'd1, 5'd0, 16'h1); ex[6]  = 2'b10; // REGIMM
    ins[7]  = itype(6'h04, 5'd1, 5'd2, 16'h1); ex[7]  = 2'b11; // BEQ
    ins[8]  = itype(6'h20, 5'd1, 5'd2, 16'h1); ex[8]  = 2'b10; // LB
    ins[9]  = itype(6'h2B, 5'd1, 5'd2, 16'h1); ex[9]  = 2'b11; // SW
    ins[10] = {6'h02, 26'h3FFFFFF};            ex[10] = 2'b00; // J
    ins[11] = itype(6'h3F, 5'd1, 5'd2, 16'h1); ex[11] = 2'b00; // unknown
    for (int i = 0; i < 12; i++) begin
      idInstruction = ins[i]; idValid = 1'b0; flush = 1'b0; hold = 1'b0;
      u.urs = ex[i][1]; u.urt = ex[i][0];
      use_q.push_back(u);
      @(negedge clk);
      u = use_q.pop_front();
      checks++;
      if (useRs !== u.urs) $display("FAIL decode%0d useRs: got %b expected %b", i, useRs, u.urs);
      else passes++;
      checks++;
      if (useRt !== u.urt) $display("FAIL decode%0d useRt: got %b expected %b", i, useRt, u.urt);
      else passes++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_forward;
    do_reset();
    cyc("s1_addi", itype(6'h08, 5'd0, 5'd1, 16'd5), 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
`ifdef HAZARD_FORWARDING_EN
    cyc("s1_add", rtype(5'd1, 5'd1, 5'd2, 6'h20), 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1);
`else
    repeat (3)
      cyc("s1_add_wait", rtype(5'd1, 5'd1, 5'd2, 6'h20), 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    cyc("s1_add", rtype(5'd1, 5'd1, 5'd2, 6'h20), 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
`endif
`ifdef HAZARD_FORWARDING_EN
    cyc("s1_sub", rtype(5'd1, 5'd0, 5'd3, 6'h22), 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0);
`else
    cyc("s1_sub", rtype(5'd1, 5'd0, 5'd3, 6'h22), 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
`endif
    idle("s1_cnt");
  endtask

  task automatic test_load_use;
    do_reset();
    cyc("s2_lw", itype(6'h23, 5'd0, 5'd4, 16'd0), 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
`ifdef HAZARD_FORWARDING_EN
    cyc("s2_add_stall", rtype(5'd4, 5'd0, 5'd5, 6'h20), 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0);
    cyc("s2_add_fwd", rtype(5'd4, 5'd0, 5'd5, 6'h20), 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0);
`else
    repeat (3)
      cyc("s2_add_stall", rtype(5'd4, 5'd0, 5'd5, 6'h20), 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    cyc("s2_add_go", rtype(5'd4, 5'd0, 5'd5, 6'h20), 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
`endif
    idle("s2_cnt");
  endtask

  task automatic test_reg_zero;
    do_reset();
    cyc("s3_addi0", itype(6'h08, 5'd0, 5'd0, 16'd7), 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    cyc("s3_add", rtype(5'd0, 5'd0, 5'd6, 6'h20), 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic test_hold;
    do_reset();
    cyc("s4_lw", itype(6'h23, 5'd0, 5'd7, 16'd0), 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
`ifdef HAZARD_FORWARDING_EN
    repeat (3)
      cyc("s4_held", itype(6'h04, 5'd7, 5'd7, 16'd4), 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 2'd1, 2'd1);
    cyc("s4_release", itype(6'h04, 5'd7, 5'd7, 16'd4), 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1);
    cyc("s4_fwd", itype(6'h04, 5'd7, 5'd7, 16'd4), 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2);
`else
    repeat (3)
      cyc("s4_held", itype(6'h04, 5'd7, 5'd7, 16'd4), 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
    repeat (3)
      cyc("s4_release", itype(6'h04, 5'd7, 5'd7, 16'd4), 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    cyc("s4_go", itype(6'h04, 5'd7, 5'd7, 16'd4), 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
`endif
    idle("s4_cnt");
  endtask

  task automatic test_flush;
    do_reset();
    cyc("s5_lw", itype(6'h23, 5'd0, 5'd8, 16'd0), 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
`ifdef HAZARD_FORWARDING_EN
    cyc("s5_flush", rtype(5'd8, 5'd0, 5'd9, 6'h20), 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0);
`else
    cyc("s5_flush", rtype(5'd8, 5'd0, 5'd9, 6'h20), 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
`endif
    // Reader of $9: the flushed ADD must not have reached EX.
    cyc("s5_bubble", rtype(5'd9, 5'd0, 5'd10, 6'h20), 1'b1, 5'd10, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
`ifdef HAZARD_FORWARDING_EN
    cyc("s5_wb_fwd", rtype(5'd8, 5'd0, 5'd11, 6'h20), 1'b1, 5'd11, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0);
`else
    cyc("s5_wb_stall", rtype(5'd8, 5'd0, 5'd11, 6'h20), 1'b1, 5'd11, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    cyc("s5_go", rtype(5'd8, 5'd0, 5'd11, 6'h20), 1'b1, 5'd11, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
`endif
    idle("s5_cnt");
  endtask

  task automatic test_saturation;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc("sat_lw", itype(6'h23, 5'd0, 5'd12, 16'd0), 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
`ifdef HAZARD_FORWARDING_EN
      cyc("sat_stall", itype(6'h04, 5'd12, 5'd12, 16'd0), 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1);
      cyc("sat_go", itype(6'h04, 5'd12, 5'd12, 16'd0), 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2);
`else
      repeat (3)
        cyc("sat_stall", itype(6'h04, 5'd12, 5'd12, 16'd0), 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
      cyc("sat_go", itype(6'h04, 5'd12, 5'd12, 16'd0), 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
`endif
    end
    idle("sat_cnt");
  endtask

  task automatic test_reset_mid;
    do_reset();
    cyc("s7_addi1", itype(6'h08, 5'd0, 5'd1, 16'd1), 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    cyc("s7_addi2", itype(6'h08, 5'd0, 5'd2, 16'd2), 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    cyc("s7_lw3", itype(6'h23, 5'd0, 5'd3, 16'd0), 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
`ifdef HAZARD_FORWARDING_EN
    cyc("s7_pre", rtype(5'd3, 5'd3, 5'd4, 6'h20), 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1);
`else
    cyc("s7_pre", rtype(5'd3, 5'd3, 5'd4, 6'h20), 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
`endif
    reset = 1'b1;
    idInstruction = rtype(5'd3, 5'd3, 5'd4, 6'h20); idValid = 1'b1; idWriteReg = 5'd4;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = '0;
    cyc("s7_rd12", rtype(5'd1, 5'd2, 5'd4, 6'h20), 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    cyc("s7_rd3", rtype(5'd3, 5'd3, 5'd5, 6'h22), 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    exp_cnt = '0;
    test_reset();
    test_decode();
    test_alu_forward();
    test_load_use();
    test_reg_zero();
    test_hold();
    test_flush();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
